// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot view controller and renderer top level.
package mandel_pkg;

    // Default fixed-point format; the renderer is built with the same values.
    localparam int FP_WIDTH_DEF = 25;
    localparam int FP_INT_DEF   = 4;
    localparam int FPF          = FP_WIDTH_DEF - FP_INT_DEF;
    localparam int FP_ONE       = 1 << FPF;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_HOME,
        CMD_ZIN,
        CMD_ZOUT,
        CMD_UP,
        CMD_DOWN,
        CMD_LFT,
        CMD_RGT
    } nav_cmd_t;

    typedef enum logic [2:0] {
        ST_READY,
        ST_APPLY,
        ST_MUL,
        ST_OFFS,
        ST_START,
        ST_WAIT
    } view_state_t;

    // Same-cycle button arbitration: home > zin > zout > up > down > lft > rgt.
    function automatic nav_cmd_t btn_to_cmd(
        input logic home,
        input logic zin,
        input logic zout,
        input logic up,
        input logic down,
        input logic lft,
        input logic rgt
    );
        nav_cmd_t c;
        c = CMD_NONE;
        if (home)      c = CMD_HOME;
        else if (zin)  c = CMD_ZIN;
        else if (zout) c = CMD_ZOUT;
        else if (up)   c = CMD_UP;
        else if (down) c = CMD_DOWN;
        else if (lft)  c = CMD_LFT;
        else if (rgt)  c = CMD_RGT;
        return c;
    endfunction

endpackage

// File: rtl/mandel_view_ctrl_mul.sv
// Sequential shift-add multiplier: signed operand times an unsigned constant,
// one constant bit per cycle. The operand must stay stable while running.
module const_mul_seq #(
    parameter int AW = 25,
    parameter int CW = 9,
    parameter int K  = 160
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [AW-1:0]    a,
    output logic signed [AW+CW-1:0] prod,
    output logic                    done
);

    localparam int PW   = AW + CW;
    localparam int CNTW = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [CW-1:0] KV = CW'(K);

    logic            run;
    logic [CNTW-1:0] bit_idx;
    logic signed [PW-1:0] a_ext;

    assign a_ext = PW'(a);
    // High during the cycle that accumulates the last constant bit.
    assign done  = run && (bit_idx == CNTW'(CW - 1));

    // Accumulate a << i for each set bit i of the constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            bit_idx <= '0;
            prod    <= '0;
        end else if (start) begin
            run     <= 1'b1;
            bit_idx <= '0;
            prod    <= '0;
        end else if (run) begin
            if (KV[bit_idx]) prod <= prod + (a_ext <<< bit_idx);
            bit_idx <= bit_idx + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/mandel_view_ctrl.sv
// View controller for render_mandel: navigation pulses -> view update ->
// corner computation -> one-cycle start, with outputs frozen while rendering.
module mandel_view_ctrl
    import mandel_pkg::*;
#(
    parameter int FP_WIDTH  = 25,
    parameter int FP_INT    = 4,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int CX_INIT   = -1572864,
    parameter int CY_INIT   = 0,
    parameter int STEP_INIT = 32768,
    parameter int STEP_MIN  = 1,
    parameter int STEP_MAX  = 65536,
    parameter int PAN_SHIFT = 4,
    parameter int CLAMP     = 4194304
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_home,
    input  logic                       btn_zin,
    input  logic                       btn_zout,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_lft,
    input  logic                       btn_rgt,
    input  logic                       render_done,
    output logic                       start,
    output logic signed [FP_WIDTH-1:0] x_start,
    output logic signed [FP_WIDTH-1:0] y_start,
    output logic signed [FP_WIDTH-1:0] step,
    output logic                       busy,
    output logic signed [5:0]          zoom_lvl
);

    localparam int HALF_W = FB_WIDTH / 2;
    localparam int HALF_H = FB_HEIGHT / 2;
    // Multiplier length sized so the constant register always has room
    // for the larger half-dimension (9 cycles at 320x180).
    localparam int MULW   = $clog2(((FB_WIDTH > FB_HEIGHT) ? FB_WIDTH : FB_HEIGHT) + 1);
    localparam int PW     = FP_WIDTH + MULW;
    localparam int SW     = FP_WIDTH + PAN_SHIFT + 2;
    localparam int FPF_L  = FP_WIDTH - FP_INT;

    // Centre saturation never exceeds what the integer field can hold.
    localparam longint FP_MAXV = (longint'(1) << (FP_INT - 1 + FPF_L)) - 1;
    localparam longint LIM     = (longint'(CLAMP) < FP_MAXV) ? longint'(CLAMP) : FP_MAXV;

    localparam logic signed [FP_WIDTH-1:0] LIM_P  = FP_WIDTH'(LIM);
    localparam logic signed [SW-1:0]       LIM_S  = SW'(LIM);
    localparam logic signed [FP_WIDTH-1:0] CX0    = FP_WIDTH'(CX_INIT);
    localparam logic signed [FP_WIDTH-1:0] CY0    = FP_WIDTH'(CY_INIT);
    localparam logic signed [FP_WIDTH-1:0] STEP0  = FP_WIDTH'(STEP_INIT);
    localparam logic signed [FP_WIDTH-1:0] SMIN_P = FP_WIDTH'(STEP_MIN);
    localparam logic signed [FP_WIDTH-1:0] SMAX_P = FP_WIDTH'(STEP_MAX);
    localparam logic signed [FP_WIDTH-1:0] X0 =
        FP_WIDTH'(longint'(CX_INIT) - longint'(STEP_INIT) * HALF_W);
    localparam logic signed [FP_WIDTH-1:0] Y0 =
        FP_WIDTH'(longint'(CY_INIT) - longint'(STEP_INIT) * HALF_H);

    view_state_t state, state_nxt;
    nav_cmd_t    cmd, pend, btn_cmd, eff_pend;

    logic signed [FP_WIDTH-1:0] cx, cy, step_v;
    logic signed [FP_WIDTH-1:0] cx_pan, cy_pan;
    logic signed [SW-1:0]       pan, dx, dy;
    logic signed [PW-1:0]       prod_x, prod_y;
    logic                       done_x, done_y, mul_go;

    function automatic logic signed [FP_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > LIM_S)       return LIM_P;
        else if (v < -LIM_S) return -LIM_P;
        else                 return v[FP_WIDTH-1:0];
    endfunction

    assign btn_cmd  = btn_to_cmd(btn_home, btn_zin, btn_zout, btn_up, btn_down, btn_lft, btn_rgt);
    // A pulse arriving with render_done is newer than the parked one.
    assign eff_pend = (btn_cmd != CMD_NONE) ? btn_cmd : pend;
    assign mul_go   = (state == ST_APPLY);

    const_mul_seq #(.AW(FP_WIDTH), .CW(MULW), .K(HALF_W)) u_mul_x (
        .clk   (clk),
        .rst   (rst),
        .start (mul_go),
        .a     (step_v),
        .prod  (prod_x),
        .done  (done_x)
    );

    const_mul_seq #(.AW(FP_WIDTH), .CW(MULW), .K(HALF_H)) u_mul_y (
        .clk   (clk),
        .rst   (rst),
        .start (mul_go),
        .a     (step_v),
        .prod  (prod_y),
        .done  (done_y)
    );

    // State register; reset lands in APPLY with HOME for the automatic first render.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_APPLY;
        else     state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_READY: begin
                busy = 1'b0;
                if (btn_cmd != CMD_NONE) state_nxt = ST_APPLY;
            end
            ST_APPLY: state_nxt = ST_MUL;
            ST_MUL:   if (done_x && done_y) state_nxt = ST_OFFS;
            ST_OFFS:  state_nxt = ST_START;
            ST_START: begin
                start     = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (render_done) state_nxt = (eff_pend != CMD_NONE) ? ST_APPLY : ST_READY;
            end
            default: state_nxt = ST_READY;
        endcase
    end

    // Command latch and one-entry pending slot (latest pulse wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd  <= CMD_HOME;
            pend <= CMD_NONE;
        end else begin
            case (state)
                ST_READY: if (btn_cmd != CMD_NONE) cmd <= btn_cmd;
                ST_WAIT: begin
                    if (render_done) begin
                        cmd  <= eff_pend;
                        pend <= CMD_NONE;
                    end else if (btn_cmd != CMD_NONE) begin
                        pend <= btn_cmd;
                    end
                end
                default: if (btn_cmd != CMD_NONE) pend <= btn_cmd;
            endcase
        end
    end

    // Pan candidates, computed wide and saturated back to the centre range.
    always_comb begin
        pan = SW'(step_v) <<< PAN_SHIFT;
        dx  = '0;
        dy  = '0;
        case (cmd)
            CMD_LFT:  dx = -pan;
            CMD_RGT:  dx = pan;
            CMD_UP:   dy = -pan;
            CMD_DOWN: dy = pan;
            default:  ;
        endcase
        cx_pan = sat(SW'(cx) + dx);
        cy_pan = sat(SW'(cy) + dy);
    end

    // View state update, applied once per command in APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx       <= CX0;
            cy       <= CY0;
            step_v   <= STEP0;
            zoom_lvl <= '0;
        end else if (state == ST_APPLY) begin
            case (cmd)
                CMD_HOME: begin
                    cx       <= CX0;
                    cy       <= CY0;
                    step_v   <= STEP0;
                    zoom_lvl <= '0;
                end
                CMD_ZIN: begin
                    if (step_v > SMIN_P) begin
                        step_v   <= step_v >>> 1;
                        zoom_lvl <= zoom_lvl + 6'sd1;
                    end
                end
                CMD_ZOUT: begin
                    if (step_v < SMAX_P) begin
                        step_v   <= step_v <<< 1;
                        zoom_lvl <= zoom_lvl - 6'sd1;
                    end
                end
                CMD_UP, CMD_DOWN: cy <= cy_pan;
                CMD_LFT, CMD_RGT: cx <= cx_pan;
                default: ;
            endcase
        end
    end

    // Renderer-facing view; only changes in OFFS so it stays frozen while rendering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_start <= X0;
            y_start <= Y0;
            step    <= STEP0;
        end else if (state == ST_OFFS) begin
            x_start <= FP_WIDTH'(PW'(cx) - prod_x);
            y_start <= FP_WIDTH'(PW'(cy) - prod_y);
            step    <= step_v;
        end
    end

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Directed bench for mandel_view_ctrl with a scoreboard of expected views.
module tb_mandel_view_ctrl;
    import mandel_pkg::*;

    localparam longint CX0   = -1572864;
    localparam longint CY0   = 0;
    localparam longint STEP0 = 32768;
    localparam longint CLMP  = 4194304;
    localparam longint SMIN  = 1;
    localparam longint SMAX  = 65536;

    localparam logic [6:0] B_HOME = 7'b1000000;
    localparam logic [6:0] B_ZIN  = 7'b0100000;
    localparam logic [6:0] B_ZOUT = 7'b0010000;
    localparam logic [6:0] B_UP   = 7'b0001000;
    localparam logic [6:0] B_LFT  = 7'b0000010;
    localparam logic [6:0] B_RGT  = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_home = 1'b0, btn_zin = 1'b0, btn_zout = 1'b0, btn_up = 1'b0;
    logic btn_down = 1'b0, btn_lft = 1'b0, btn_rgt = 1'b0;
    logic render_done = 1'b0;
    logic start, busy;
    logic signed [24:0] x_start, y_start, step;
    logic signed [5:0]  zoom_lvl;

    typedef struct {
        longint x;
        longint y;
        longint st;
        longint z;
    } exp_t;

    exp_t   sb[$];
    longint m_cx, m_cy, m_st, m_z;
    int     vectors = 0;
    int     miscompares = 0;

    always #5 clk = ~clk;

    mandel_view_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .btn_home    (btn_home),
        .btn_zin     (btn_zin),
        .btn_zout    (btn_zout),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_lft     (btn_lft),
        .btn_rgt     (btn_rgt),
        .render_done (render_done),
        .start       (start),
        .x_start     (x_start),
        .y_start     (y_start),
        .step        (step),
        .busy        (busy),
        .zoom_lvl    (zoom_lvl)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > CLMP)  return CLMP;
        if (v < -CLMP) return -CLMP;
        return v;
    endfunction

    // Reference view model; each applied command queues the view the DUT must show.
    task automatic model_apply(input nav_cmd_t c);
        case (c)
            CMD_HOME: begin m_cx = CX0; m_cy = CY0; m_st = STEP0; m_z = 0; end
            CMD_ZIN:  if (m_st > SMIN) begin m_st = m_st / 2; m_z = m_z + 1; end
            CMD_ZOUT: if (m_st < SMAX) begin m_st = m_st * 2; m_z = m_z - 1; end
            CMD_UP:   m_cy = sat(m_cy - m_st * 16);
            CMD_DOWN: m_cy = sat(m_cy + m_st * 16);
            CMD_LFT:  m_cx = sat(m_cx - m_st * 16);
            CMD_RGT:  m_cx = sat(m_cx + m_st * 16);
            default:  ;
        endcase
        sb.push_back('{m_cx - m_st * 160, m_cy - m_st * 90, m_st, m_z});
    endtask

    task automatic set_btns(input logic [6:0] b);
        {btn_home, btn_zin, btn_zout, btn_up, btn_down, btn_lft, btn_rgt} = b;
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        chk({tag, " queued"}, longint'(sb.size()), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " x_start"}, longint'(x_start), e.x);
            chk({tag, " y_start"}, longint'(y_start), e.y);
            chk({tag, " step"}, longint'(step), e.st);
            chk({tag, " zoom_lvl"}, longint'(zoom_lvl), e.z);
        end
    endtask

    // Wait (bounded) for start, check latency if given, then the scoreboard and pulse width.
    task automatic wait_start(input string tag, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            set_btns('0);
            lat++;
            got = start;
        end
        if (exp_lat >= 0) chk({tag, " latency"}, got ? longint'(lat) : -1, exp_lat);
        else              chk({tag, " start seen"}, longint'(got), 1);
        check_sb(tag);
        @(negedge clk);
        chk({tag, " start width"}, longint'(start), 0);
    endtask

    task automatic press(input logic [6:0] b, input nav_cmd_t eff);
        @(negedge clk);
        set_btns(b);
        model_apply(eff);
    endtask

    task automatic done_pulse();
        @(negedge clk);
        render_done = 1'b1;
        @(negedge clk);
        render_done = 1'b0;
    endtask

    task automatic finish_render(input string tag);
        done_pulse();
        chk({tag, " idle busy"}, longint'(busy), 0);
    endtask

    task automatic nav(input logic [6:0] b, input nav_cmd_t eff, input string tag);
        press(b, eff);
        wait_start(tag, 12);
        finish_render(tag);
    endtask

    initial begin
        bit seen;

        // Reset state and automatic home render.
        repeat (2) @(negedge clk);
        chk("rst busy", longint'(busy), 1);
        chk("rst start", longint'(start), 0);
        chk("rst x_start", longint'(x_start), -6815744);
        chk("rst y_start", longint'(y_start), -2949120);
        chk("rst step", longint'(step), 32768);
        chk("rst zoom", longint'(zoom_lvl), 0);
        model_apply(CMD_HOME);
        rst = 1'b0;
        wait_start("auto home", -1);
        chk("wait busy", longint'(busy), 1);
        finish_render("auto home");

        // Zoom in from home.
        nav(B_ZIN, CMD_ZIN, "zin");

        // Pan right from home, then until saturation.
        nav(B_HOME, CMD_HOME, "home1");
        for (int i = 0; i < 12; i++) nav(B_RGT, CMD_RGT, $sformatf("rgt%0d", i));

        // Same-cycle priority, then three pulses parked during WAIT.
        nav(B_HOME, CMD_HOME, "home2");
        press(B_ZIN | B_LFT, CMD_ZIN);
        wait_start("zin+lft", 12);
        @(negedge clk); set_btns(B_ZIN);
        @(negedge clk); set_btns(B_LFT);
        @(negedge clk); set_btns(B_UP);
        @(negedge clk); set_btns('0);
        model_apply(CMD_UP);
        done_pulse();
        wait_start("pending up", -1);
        done_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start) seen = 1'b1;
        end
        chk("no extra render", longint'(seen), 0);
        chk("pending idle busy", longint'(busy), 0);

        // Step limits: zoom in to STEP_MIN and out to STEP_MAX.
        nav(B_HOME, CMD_HOME, "home3");
        for (int i = 0; i < 15; i++) nav(B_ZIN, CMD_ZIN, $sformatf("zin%0d", i));
        nav(B_ZIN, CMD_ZIN, "zin at min");
        nav(B_HOME, CMD_HOME, "home4");
        nav(B_ZOUT, CMD_ZOUT, "zout");
        nav(B_ZOUT, CMD_ZOUT, "zout at max");

        // Reset during WAIT after several zooms.
        nav(B_HOME, CMD_HOME, "home5");
        nav(B_ZIN, CMD_ZIN, "rz0");
        nav(B_ZIN, CMD_ZIN, "rz1");
        press(B_ZIN, CMD_ZIN);
        wait_start("rz2", 12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst x_start", longint'(x_start), -6815744);
        chk("mid rst y_start", longint'(y_start), -2949120);
        chk("mid rst step", longint'(step), 32768);
        chk("mid rst zoom", longint'(zoom_lvl), 0);
        chk("mid rst busy", longint'(busy), 1);
        chk("mid rst start", longint'(start), 0);
        model_apply(CMD_HOME);
        @(negedge clk);
        rst = 1'b0;
        wait_start("post rst home", -1);
        finish_render("post rst home");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
